// File: rtl/inject_port.sv
// Injection port: per-VC flit FIFOs, credit-based flow control, round-robin VC arbiter.
// Define INJECT_PORT_STATS_EN to add the flits_sent / pkts_sent counters.
module inject_port #(
    parameter int unsigned NUM_VC  = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned FLIT_W  = 16,
    parameter int unsigned CREDITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [FLIT_W-1:0]         in_flit,
    input  logic [$clog2(NUM_VC)-1:0] in_vc,
    output logic [NUM_VC-1:0]         in_ready,
    output logic                      out_valid,
    output logic [FLIT_W-1:0]         out_flit,
    output logic [$clog2(NUM_VC)-1:0] out_vc,
    input  logic [NUM_VC-1:0]         credit_in,
    output logic                      credit_err
`ifdef INJECT_PORT_STATS_EN
    ,
    output logic [31:0]               flits_sent,
    output logic [31:0]               pkts_sent
`endif
);

    localparam int unsigned VW   = $clog2(NUM_VC);
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = $clog2(DEPTH) + 1;
    localparam int unsigned CW   = $clog2(CREDITS) + 1;

    localparam logic [CNTW-1:0] DEPTH_CNT = CNTW'(DEPTH);
    localparam logic [CW-1:0]   CRED_MAX  = CW'(CREDITS);
    localparam logic [PW-1:0]   LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [VW-1:0]   LAST_VC   = VW'(NUM_VC - 1);

    logic [FLIT_W-1:0] r_mem    [NUM_VC][DEPTH];
    logic [PW-1:0]     r_wr_ptr [NUM_VC];
    logic [PW-1:0]     r_rd_ptr [NUM_VC];
    logic [CNTW-1:0]   r_cnt    [NUM_VC];
    logic [CW-1:0]     r_credit [NUM_VC];
    logic [VW-1:0]     r_rr;
    logic              r_out_valid;
    logic [FLIT_W-1:0] r_out_flit;
    logic [VW-1:0]     r_out_vc;
    logic              r_credit_err;

    logic [NUM_VC-1:0] w_full;
    logic [NUM_VC-1:0] w_elig;
    logic [NUM_VC-1:0] w_push_vc;
    logic [NUM_VC-1:0] w_pop_vc;
    logic              w_vc_ok;
    logic              w_push;
    logic              w_hi_vld;
    logic              w_lo_vld;
    logic [VW-1:0]     w_hi_vc;
    logic [VW-1:0]     w_lo_vc;
    logic              w_gnt_vld;
    logic [VW-1:0]     w_gnt_vc;

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            w_full[v] = (r_cnt[v] == DEPTH_CNT);
            w_elig[v] = (r_cnt[v] != '0) && (r_credit[v] != '0);
        end
    end

    assign in_ready = ~w_full;

    // Non-power-of-two NUM_VC leaves unused in_vc codes; those are never accepted.
    assign w_vc_ok = (32'(in_vc) < NUM_VC);
    assign w_push  = in_valid && w_vc_ok && !w_full[in_vc];

    // Round-robin: lowest eligible VC at or above the pointer, else lowest eligible overall.
    always_comb begin
        w_hi_vld = 1'b0;
        w_lo_vld = 1'b0;
        w_hi_vc  = '0;
        w_lo_vc  = '0;
        for (int v = NUM_VC - 1; v >= 0; v--) begin
            if (w_elig[v]) begin
                w_lo_vld = 1'b1;
                w_lo_vc  = VW'(v);
                if (VW'(v) >= r_rr) begin
                    w_hi_vld = 1'b1;
                    w_hi_vc  = VW'(v);
                end
            end
        end
        w_gnt_vld = w_hi_vld || w_lo_vld;
        w_gnt_vc  = w_hi_vld ? w_hi_vc : w_lo_vc;
    end

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            w_push_vc[v] = w_push && (in_vc == VW'(v));
            w_pop_vc[v]  = w_gnt_vld && (w_gnt_vc == VW'(v));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[in_vc][r_wr_ptr[in_vc]] <= in_flit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                r_wr_ptr[v] <= '0;
                r_rd_ptr[v] <= '0;
                r_cnt[v]    <= '0;
                r_credit[v] <= CRED_MAX;
            end
            r_credit_err <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (w_push_vc[v]) begin
                    r_wr_ptr[v] <= (r_wr_ptr[v] == LAST_PTR) ? '0 : r_wr_ptr[v] + 1'b1;
                end
                if (w_pop_vc[v]) begin
                    r_rd_ptr[v] <= (r_rd_ptr[v] == LAST_PTR) ? '0 : r_rd_ptr[v] + 1'b1;
                end
                case ({w_push_vc[v], w_pop_vc[v]})
                    2'b10:   r_cnt[v] <= r_cnt[v] + 1'b1;
                    2'b01:   r_cnt[v] <= r_cnt[v] - 1'b1;
                    default: r_cnt[v] <= r_cnt[v];
                endcase
                // A returned credit with no room to hold it is a protocol error upstream.
                if (credit_in[v] && !w_pop_vc[v]) begin
                    if (r_credit[v] == CRED_MAX) begin
                        r_credit_err <= 1'b1;
                    end else begin
                        r_credit[v] <= r_credit[v] + 1'b1;
                    end
                end else if (!credit_in[v] && w_pop_vc[v]) begin
                    r_credit[v] <= r_credit[v] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr        <= '0;
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
            r_out_vc    <= '0;
        end else begin
            r_out_valid <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_rr       <= (w_gnt_vc == LAST_VC) ? '0 : w_gnt_vc + 1'b1;
                r_out_flit <= r_mem[w_gnt_vc][r_rd_ptr[w_gnt_vc]];
                r_out_vc   <= w_gnt_vc;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_flit   = r_out_flit;
    assign out_vc     = r_out_vc;
    assign credit_err = r_credit_err;

`ifdef INJECT_PORT_STATS_EN
    logic [31:0] r_flits_sent;
    logic [31:0] r_pkts_sent;
    logic        w_gnt_tail;

    assign w_gnt_tail = r_mem[w_gnt_vc][r_rd_ptr[w_gnt_vc]][FLIT_W-2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flits_sent <= '0;
            r_pkts_sent  <= '0;
        end else if (w_gnt_vld) begin
            r_flits_sent <= r_flits_sent + 32'd1;
            if (w_gnt_tail) begin
                r_pkts_sent <= r_pkts_sent + 32'd1;
            end
        end
    end

    assign flits_sent = r_flits_sent;
    assign pkts_sent  = r_pkts_sent;
`endif

endmodule

// File: tb/tb_inject_port.sv
// Scoreboard bench for inject_port: stimulus queues expected flits, a negedge monitor checks them.
module tb_inject_port;

    typedef struct packed {
        logic        vc;
        logic [15:0] flit;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid;
    logic [15:0] in_flit;
    logic        in_vc;
    logic [1:0]  in_ready;
    logic        out_valid;
    logic [15:0] out_flit;
    logic        out_vc;
    logic [1:0]  credit_in;
    logic        credit_err;
`ifdef INJECT_PORT_STATS_EN
    logic [31:0] flits_sent;
    logic [31:0] pkts_sent;
`endif

    exp_t exp_q[$];
    int   vc_log[$];
    int   cyc_log[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_emit  = 0;
    int   cyc     = 0;
    int   alt_vc[16] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 1, 0, 1, 0, 1, 0, 1};

    inject_port #(
        .NUM_VC (2),
        .DEPTH  (4),
        .FLIT_W (16),
        .CREDITS(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_flit   (in_flit),
        .in_vc     (in_vc),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_flit  (out_flit),
        .out_vc    (out_vc),
        .credit_in (credit_in),
        .credit_err(credit_err)
`ifdef INJECT_PORT_STATS_EN
        ,
        .flits_sent(flits_sent),
        .pkts_sent (pkts_sent)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: match each output flit to the oldest expected flit of the same VC.
    always @(negedge clk) begin
        int idx;
        if (!rst && out_valid) begin
            idx = -1;
            n_emit++;
            vc_log.push_back(int'(out_vc));
            cyc_log.push_back(cyc);
            for (int i = 0; i < exp_q.size(); i++) begin
                if (idx < 0 && exp_q[i].vc == out_vc) idx = i;
            end
            if (idx < 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_flit: got vc %0d flit %0h, required no output",
                         out_vc, out_flit);
            end else begin
                check("flit_order", 32'(out_flit), 32'(exp_q[idx].flit));
                exp_q.delete(idx);
            end
        end
    end

    task automatic push(input int vc, input logic [15:0] f);
        exp_t e;
        int   w;
        w = 0;
        while (!in_ready[vc] && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("push_ready", 32'(in_ready[vc]), 32'd1);
        if (in_ready[vc]) begin
            in_valid = 1'b1;
            in_vc    = 1'(vc);
            in_flit  = f;
            e.vc     = 1'(vc);
            e.flit   = f;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        credit_in = '0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_flit", 32'(out_flit), 32'd0);
        check("rst_out_vc", 32'(out_vc), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd3);
        check("rst_credit_err", 32'(credit_err), 32'd0);
        exp_q.delete();
        vc_log.delete();
        cyc_log.delete();
        n_emit = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        in_valid  = 1'b0;
        in_flit   = '0;
        in_vc     = 1'b0;
        credit_in = '0;
        #2;

        // Three-flit packet on VC0, one-cycle latency, credits consumed.
        do_reset();
        push(0, 16'h8001);
        check("no_bypass", 32'(out_valid), 32'd0);
        push(0, 16'h0002);
        push(0, 16'h4003);
        cycles(3);
        check("pkt_emit_cnt", n_emit, 3);
        check("credit0_left", 32'(dut.r_credit[0]), 32'd1);

        // Credit starvation fills VC1; a single credit releases a single flit.
        do_reset();
        for (int i = 0; i < 8; i++) push(1, 16'h0100 + 16'(i));
        check("vc1_full_ready", 32'(in_ready[1]), 32'd0);
        check("vc1_emit4", n_emit, 4);
        in_valid = 1'b1;
        in_vc    = 1'b1;
        in_flit  = 16'h0108;
        cycles(3);
        check("vc1_hold_ready", 32'(in_ready[1]), 32'd0);
        check("vc1_hold_emit", n_emit, 4);
        credit_in = 2'b10;
        cycles(1);
        credit_in = '0;
        cycles(1);
        check("vc1_credit_out", 32'(out_valid), 32'd1);
        check("vc1_ready_again", 32'(in_ready[1]), 32'd1);
        exp_q.push_back('{vc: 1'b1, flit: 16'h0108});
        cycles(1);
        in_valid = 1'b0;
        cycles(4);
        check("vc1_emit5", n_emit, 5);
        check("vc1_refull", 32'(in_ready[1]), 32'd0);

        // Both VCs full, credits returned: strict alternation 0,1,0,1...
        do_reset();
        for (int i = 0; i < 4; i++) push(0, 16'h0200 + 16'(i));
        for (int i = 0; i < 4; i++) push(1, 16'h0300 + 16'(i));
        cycles(4);
        check("alt_prelim_emit", n_emit, 8);
        for (int i = 0; i < 4; i++) push(0, 16'h0210 + 16'(i));
        for (int i = 0; i < 4; i++) push(1, 16'h0310 + 16'(i));
        check("alt_full_ready", 32'(in_ready), 32'd0);
        credit_in = 2'b11;
        cycles(4);
        credit_in = '0;
        cycles(12);
        check("alt_log_size", vc_log.size(), 16);
        if (vc_log.size() == 16) begin
            for (int i = 0; i < 16; i++) check("alt_vc_seq", vc_log[i], alt_vc[i]);
            check("alt_consecutive", cyc_log[15] - cyc_log[8], 7);
        end

        // Credit overflow is sticky until reset.
        do_reset();
        cycles(1);
        check("err_idle", 32'(credit_err), 32'd0);
        credit_in = 2'b01;
        cycles(1);
        credit_in = '0;
        check("err_set", 32'(credit_err), 32'd1);
        check("err_credit_held", 32'(dut.r_credit[0]), 32'd4);
        cycles(3);
        check("err_sticky", 32'(credit_err), 32'd1);

        // Reset with flits buffered mid-packet discards them.
        do_reset();
        for (int i = 0; i < 4; i++) push(0, 16'h0400 + 16'(i));
        cycles(3);
        push(0, 16'h8410);
        push(0, 16'h0411);
        push(0, 16'h0412);
        check("mid_pkt_emit", n_emit, 4);
        check("mid_pkt_buffered", 32'(dut.r_cnt[0]), 32'd3);
        #2;
        do_reset();
        cycles(1);
        check("post_rst_no_out", 32'(out_valid), 32'd0);
        check("post_rst_ready", 32'(in_ready), 32'd3);
        cycles(5);
        check("post_rst_no_stale", n_emit, 0);

`ifdef INJECT_PORT_STATS_EN
        do_reset();
        push(0, 16'h8501);
        push(0, 16'h0502);
        push(0, 16'h4503);
        push(1, 16'h8601);
        push(1, 16'h0602);
        push(1, 16'h4603);
        cycles(6);
        check("stats_flits", flits_sent, 32'd6);
        check("stats_pkts", pkts_sent, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
